// File: rtl/exe_mdu_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package exe_mdu_pkg;

    localparam int MD_OP_LENGTH = 3;

    typedef enum logic [MD_OP_LENGTH-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_e;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    function automatic logic is_muldiv(input logic [MD_OP_LENGTH-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [MD_OP_LENGTH-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [MD_OP_LENGTH-1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/exe_mdu_core.sv
// Iterative radix-2 shift-add multiplier / restoring divider on unsigned magnitudes.
module mdu_core #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] result,
    output logic               last
);

    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [CNT_W-1:0]   cnt;
    logic               div_q;
    logic [WIDTH:0]     add_sum, shifted;
    logic [WIDTH+1:0]   trial;

    // mul: a_q = multiplicand, b_q = multiplier (consumed LSB first)
    // div: acc = remainder:quotient, b_q = divisor
    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, b_q};
        acc_nxt = {add_sum, acc[WIDTH-1:1]};
        if (div_q) begin
            if (!trial[WIDTH+1])
                acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt   <= '0;
            div_q <= 1'b0;
        end else if (start) begin
            acc   <= is_div ? {{WIDTH{1'b0}}, op_a} : '0;
            a_q   <= op_a;
            b_q   <= op_b;
            cnt   <= '0;
            div_q <= is_div;
        end else if (step) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (!div_q)
                b_q <= {1'b0, b_q[WIDTH-1:1]};
        end
    end

    assign result = acc;
    assign last   = (cnt == CNT_W'(ITER - 1));

endmodule

// File: rtl/exe_mdu.sv
// EX-stage multiply/divide unit: owns HI/LO, sequences the iterative core, stalls the pipe.
//   state | meaning
//   IDLE  | HI/LO stable; accepts MTHI/MTLO and mul/div issue
//   CALC  | one core iteration per cycle, ITER cycles
//   FIX   | sign/div-by-zero correction, HI/LO written at exit edge
module exe_mdu
    import exe_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32,
    parameter int CNT_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [MD_OP_LENGTH-1:0] mdOpE,
    input  logic                    mdValidE,
    input  logic [WIDTH-1:0]        SrcA,
    input  logic [WIDTH-1:0]        SrcB,
    input  logic                    flushE,
    output logic [WIDTH-1:0]        hiE,
    output logic [WIDTH-1:0]        loE,
    output logic                    mdStallE,
    output logic                    mdDoneE
);

    mdu_state_e         state, state_nxt;
    logic               issue_md, op_signed, core_last;
    logic               is_div_q, neg_res_q, neg_rem_q, dz_q;
    logic [WIDTH-1:0]   a_raw_q, hi_q, lo_q, mag_a, mag_b, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] core_res, prod_fix;

    // 33-bit intermediate so |0x80000000| comes out as 0x80000000 unsigned
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH:0] ext;
        ext = {sgn & v[WIDTH-1], v};
        if (ext[WIDTH])
            ext = -ext;
        return ext[WIDTH-1:0];
    endfunction

    assign op_signed = is_signed_op(mdOpE);
    assign issue_md  = (state == MDU_IDLE) && mdValidE && !flushE && is_muldiv(mdOpE);
    assign mag_a     = magnitude(SrcA, op_signed);
    assign mag_b     = magnitude(SrcB, op_signed);

    mdu_core #(.WIDTH(WIDTH), .ITER(ITER), .CNT_W(CNT_W)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (issue_md),
        .step   (state == MDU_CALC),
        .is_div (is_div_op(mdOpE)),
        .op_a   (mag_a),
        .op_b   (mag_b),
        .result (core_res),
        .last   (core_last)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            MDU_IDLE: if (issue_md) state_nxt = MDU_CALC;
            MDU_CALC: begin
                if (flushE)         state_nxt = MDU_IDLE;
                else if (core_last) state_nxt = MDU_FIX;
            end
            MDU_FIX:  state_nxt = MDU_IDLE;
            default:  state_nxt = MDU_IDLE;
        endcase
    end

    always_comb begin
        prod_fix = neg_res_q ? -core_res : core_res;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            fix_lo = neg_res_q ? -core_res[WIDTH-1:0] : core_res[WIDTH-1:0];
            fix_hi = neg_rem_q ? -core_res[2*WIDTH-1:WIDTH] : core_res[2*WIDTH-1:WIDTH];
            if (dz_q) begin
                fix_hi = a_raw_q;
                fix_lo = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MDU_IDLE;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            a_raw_q   <= '0;
        end else begin
            state <= state_nxt;
            if (issue_md) begin
                is_div_q  <= is_div_op(mdOpE);
                neg_res_q <= op_signed && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                neg_rem_q <= op_signed && SrcA[WIDTH-1];
                dz_q      <= is_div_op(mdOpE) && (SrcB == '0);
                a_raw_q   <= SrcA;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == MDU_IDLE) begin
            if (mdValidE && !flushE && mdOpE == MD_MTHI) hi_q <= SrcA;
            if (mdValidE && !flushE && mdOpE == MD_MTLO) lo_q <= SrcA;
        end else if (state == MDU_FIX && !flushE) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
        end
    end

    assign hiE      = hi_q;
    assign loE      = lo_q;
    assign mdStallE = issue_md || (state != MDU_IDLE);
    assign mdDoneE  = (state == MDU_FIX) && !flushE;

endmodule

// File: tb/tb_exe_mdu.sv
// Randomized self-checking bench for exe_mdu against an arithmetic reference model.
module tb_exe_mdu;
    import exe_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  mdOpE;
    logic        mdValidE;
    logic [31:0] SrcA, SrcB;
    logic        flushE;
    logic [31:0] hiE, loE;
    logic        mdStallE, mdDoneE;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    int          m_pend;

    exe_mdu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mdOpE    (mdOpE),
        .mdValidE (mdValidE),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .flushE   (flushE),
        .hiE      (hiE),
        .loE      (loE),
        .mdStallE (mdStallE),
        .mdDoneE  (mdDoneE)
    );

    always #5 clk = ~clk;

    function automatic logic md_op(input logic [2:0] op);
        return op >= 3'd1 && op <= 3'd4;
    endfunction

    // {HI, LO} the architecture requires for a mul/div op
    function automatic logic [63:0] ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     sa, sb;
        logic [63:0] r;
        sa = a;
        sb = b;
        r  = 64'h0;
        case (op)
            MD_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                r = p;
            end
            MD_MULTU: r = {32'h0, a} * {32'h0, b};
            MD_DIVU: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            MD_DIV: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else r = {32'(sa % sb), 32'(sa / sb)};
            end
            default: r = 64'h0;
        endcase
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   <= 32'h0;
            m_lo   <= 32'h0;
            m_res  <= 64'h0;
            m_pend <= 0;
        end else if (m_pend != 0) begin
            if (flushE) m_pend <= 0;
            else if (m_pend == 1) begin
                m_hi   <= m_res[63:32];
                m_lo   <= m_res[31:0];
                m_pend <= 0;
            end else m_pend <= m_pend - 1;
        end else if (mdValidE && !flushE) begin
            if (mdOpE == MD_MTHI) m_hi <= SrcA;
            else if (mdOpE == MD_MTLO) m_lo <= SrcA;
            else if (md_op(mdOpE)) begin
                m_res  <= ref_calc(mdOpE, SrcA, SrcB);
                m_pend <= 33;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("hiE", 64'(hiE), 64'(m_hi));
            chk("loE", 64'(loE), 64'(m_lo));
            chk("mdStallE", 64'(mdStallE),
                64'((m_pend != 0) || (mdValidE && md_op(mdOpE) && !flushE)));
            chk("mdDoneE", 64'(mdDoneE), 64'((m_pend == 1) && !flushE));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input bit garbage,
                          output int stalls, output int dones);
        bit ended;
        stalls   = 0;
        dones    = 0;
        ended    = 0;
        mdOpE    = op;
        SrcA     = a;
        SrcB     = b;
        mdValidE = 1'b1;
        flushE   = (flush_at == 0);
        for (int c = 0; c < 45; c++) begin
            #1;
            if (!mdStallE) begin
                ended = 1;
                break;
            end
            stalls++;
            if (mdDoneE) dones++;
            step();
            mdValidE = 1'b0;
            mdOpE    = MD_NONE;
            flushE   = (c + 1 == flush_at);
            if (garbage && c + 1 < 30 && (flush_at < 0 || c + 1 < flush_at)) begin
                mdValidE = 1'($urandom % 2);
                mdOpE    = 3'($urandom % 8);
                SrcA     = $urandom;
                SrcB     = $urandom;
            end
        end
        if (!ended) chk("stall timeout", 64'(stalls), 64'd34);
        mdValidE = 1'b0;
        mdOpE    = MD_NONE;
        flushE   = 1'b0;
        step();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom % 8)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'(int'($urandom % 16) - 8);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int st, dn;
        logic [2:0] rop;
        rst_n    = 1'b0;
        mdOpE    = MD_NONE;
        mdValidE = 1'b0;
        SrcA     = 32'h0;
        SrcB     = 32'h0;
        flushE   = 1'b0;

        chk("model mult", ref_calc(MD_MULT, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
        chk("model divu", ref_calc(MD_DIVU, 32'd100, 32'd7), 64'h0000_0002_0000_000E);
        chk("model div", ref_calc(MD_DIV, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model ovf", ref_calc(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        #1;
        chk("reset hi", 64'(hiE), 64'h0);
        chk("reset stall", 64'(mdStallE), 64'h0);
        fork
            compare_loop();
        join_none
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, -1, 1'b0, st, dn);
        chk("mult stall cycles", 64'(st), 64'd34);
        chk("mult done pulses", 64'(dn), 64'd1);
        chk("mult hi", 64'(hiE), 64'hFFFF_FFFF);
        chk("mult lo", 64'(loE), 64'hFFFF_FFF1);

        run_op(MD_DIVU, 32'd100, 32'd7, -1, 1'b1, st, dn);
        chk("divu lo", 64'(loE), 64'h0000_000E);
        chk("divu hi", 64'(hiE), 64'h0000_0002);

        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, st, dn);
        chk("div lo", 64'(loE), 64'hFFFF_FFFD);
        chk("div hi", 64'(hiE), 64'hFFFF_FFFF);

        run_op(MD_DIV, 32'h1234_5678, 32'd0, -1, 1'b0, st, dn);
        chk("dz stall cycles", 64'(st), 64'd34);
        chk("dz hi", 64'(hiE), 64'h1234_5678);
        chk("dz lo", 64'(loE), 64'hFFFF_FFFF);

        mdValidE = 1'b1;
        mdOpE    = MD_MTHI;
        SrcA     = 32'hDEAD_BEEF;
        #1 chk("mthi stall", 64'(mdStallE), 64'h0);
        step();
        chk("mthi hi", 64'(hiE), 64'hDEAD_BEEF);
        mdOpE = MD_MTLO;
        SrcA  = 32'h0BAD_F00D;
        #1 chk("mtlo stall", 64'(mdStallE), 64'h0);
        step();
        chk("mtlo lo", 64'(loE), 64'h0BAD_F00D);
        mdValidE = 1'b0;
        mdOpE    = MD_NONE;
        step();

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 1'b0, st, dn);
        chk("flush stall cycles", 64'(st), 64'd11);
        chk("flush done pulses", 64'(dn), 64'd0);
        chk("flush hi hold", 64'(hiE), 64'hDEAD_BEEF);
        chk("flush lo hold", 64'(loE), 64'h0BAD_F00D);

        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, st, dn);
        chk("ovf lo", 64'(loE), 64'h8000_0000);
        chk("ovf hi", 64'(hiE), 64'h0);

        for (int i = 0; i < 120; i++) begin
            rop = 3'($urandom_range(1, 6));
            if (rop == MD_MTHI || rop == MD_MTLO) begin
                mdValidE = 1'b1;
                mdOpE    = rop;
                SrcA     = $urandom;
                flushE   = ($urandom % 4 == 0);
                step();
                mdValidE = 1'b0;
                flushE   = 1'b0;
            end else begin
                run_op(rop, pick_operand(), pick_operand(),
                       ($urandom % 5 == 0) ? int'($urandom_range(0, 33)) : -1,
                       1'($urandom % 2), st, dn);
            end
            repeat ($urandom % 3) step();
        end

        mdValidE = 1'b1;
        mdOpE    = MD_MULTU;
        SrcA     = 32'h0001_0000;
        SrcB     = 32'h0003_0000;
        step();
        mdValidE = 1'b0;
        mdOpE    = MD_NONE;
        repeat (5) step();
        #3 rst_n = 1'b0;
        #1;
        chk("async rst hi", 64'(hiE), 64'h0);
        chk("async rst lo", 64'(loE), 64'h0);
        chk("async rst stall", 64'(mdStallE), 64'h0);
        chk("async rst done", 64'(mdDoneE), 64'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (40) step();
        chk("post rst hi", 64'(hiE), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
